vga_pixel_fetch: RTL and testbench

- Prefetch stage between the processor's pixel memory read port and the VGA raster output.
- Walks the framebuffer address space one frame at a time and issues reads ahead of the raster.
- Absorbs variable memory read latency in a small FIFO.
- Delivers one 4-bit pixel per raster request, aligned to the visible region.
- Replaces direct raster-address-to-memory coupling, so memory latency no longer corrupts displayed pixels.

---
 rtl/vga_pixel_fetch_if.sv | 26 ++
 rtl/vga_pixel_fetch.sv | 173 +++++++++++++++++
 tb/tb_vga_pixel_fetch.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pixel_fetch_if.sv
// Signal bundle between the pixel prefetcher, the pixel memory read port and the VGA raster.
// master = prefetcher side, slave = memory/raster side.
interface vga_pixel_fetch_if #(
  parameter int ADDR_W = 24,
  parameter int PIX_W  = 4
);
  logic              frame_start;
  logic              pixel_req;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rvalid;
  logic [15:0]       mem_rdata;
  logic [PIX_W-1:0]  pixel_data;
  logic              pixel_valid;
  logic              underflow;

  modport master (
    input  frame_start, pixel_req, mem_rvalid, mem_rdata,
    output mem_rd, mem_addr, pixel_data, pixel_valid, underflow
  );

  modport slave (
    output frame_start, pixel_req, mem_rvalid, mem_rdata,
    input  mem_rd, mem_addr, pixel_data, pixel_valid, underflow
  );
endinterface

// File: rtl/vga_pixel_fetch.sv
// Pixel prefetcher: issues framebuffer reads ahead of the raster and buffers returns in a small FIFO.
// Optional macro PIXEL_PACK_EN: four 4-bit pixels per 16-bit memory word.
module vga_pixel_fetch #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int ADDR_W     = 24,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 8,
  parameter int PIX_W      = 4
) (
  input logic               clk,
  input logic               rst,
  vga_pixel_fetch_if.master bus_io
);

`ifdef PIXEL_PACK_EN
  localparam int PIX_PER_WORD = 4;
  localparam int ENTRY_W      = 16;
`else
  localparam int PIX_PER_WORD = 1;
  localparam int ENTRY_W      = PIX_W;
`endif
  localparam int WORDS = H_ACTIVE * V_ACTIVE / PIX_PER_WORD;
  localparam int CNT_W = $clog2(WORDS + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  state_e             stateQ, stateD;
  logic [ADDR_W-1:0]  addrQ, addrD;
  logic [CNT_W-1:0]   fetchedQ, fetchedD;
  logic [OCC_W-1:0]   outstQ, outstD;
  logic [OCC_W-1:0]   discardQ, discardD;
  logic [OCC_W-1:0]   countQ, countD;
  logic [PTR_W-1:0]   rdPtrQ, rdPtrD;
  logic [PTR_W-1:0]   wrPtrQ, wrPtrD;
  logic [PIX_W-1:0]   pixDataQ, pixDataD;
  logic               pixValidQ, pixValidD;
  logic               underflowQ, underflowD;
  logic [ENTRY_W-1:0] fifoMem [FIFO_DEPTH];

  logic               memRd, rvLive, push, pop, popWord;
  logic [ENTRY_W-1:0] pushData;
  logic [PIX_W-1:0]   headPix;

  // Credit check counts both buffered and in-flight words so every return has a slot.
  assign memRd  = (stateQ == FETCH) && !bus_io.frame_start &&
                  (({1'b0, countQ} + {1'b0, outstQ}) < (OCC_W+1)'(FIFO_DEPTH));
  assign rvLive = bus_io.mem_rvalid && (outstQ != '0);
  assign push   = rvLive && (discardQ == '0) && !bus_io.frame_start;
  assign pop    = bus_io.pixel_req && !bus_io.frame_start && (countQ != '0);

`ifdef PIXEL_PACK_EN
  logic [1:0] idxQ, idxD;
  assign pushData = bus_io.mem_rdata;
  assign headPix  = fifoMem[rdPtrQ][{idxQ, 2'b00} +: PIX_W];
  assign popWord  = pop && (idxQ == 2'd3);
`else
  logic unusedRdata;
  assign unusedRdata = ^bus_io.mem_rdata[15:PIX_W];
  assign pushData    = bus_io.mem_rdata[PIX_W-1:0];
  assign headPix     = fifoMem[rdPtrQ];
  assign popWord     = pop;
`endif

  // Next-state logic; a frame_start flushes the FIFO and restarts the walk from any state.
  always_comb begin
    stateD     = stateQ;
    addrD      = addrQ;
    fetchedD   = fetchedQ;
    outstD     = outstQ + OCC_W'(memRd) - OCC_W'(rvLive);
    discardD   = discardQ;
    countD     = countQ + OCC_W'(push) - OCC_W'(popWord);
    rdPtrD     = popWord ? rdPtrQ + 1'b1 : rdPtrQ;
    wrPtrD     = push ? wrPtrQ + 1'b1 : wrPtrQ;
    pixDataD   = pixDataQ;
    pixValidD  = 1'b0;
    underflowD = underflowQ;
`ifdef PIXEL_PACK_EN
    idxD       = pop ? idxQ + 2'd1 : idxQ;
`endif

    if (bus_io.frame_start) begin
      stateD   = FETCH;
      addrD    = BASE;
      fetchedD = '0;
      discardD = outstQ - OCC_W'(rvLive);
      countD   = '0;
      rdPtrD   = '0;
      wrPtrD   = '0;
`ifdef PIXEL_PACK_EN
      idxD     = 2'd0;
`endif
    end else begin
      if (rvLive && (discardQ != '0)) begin
        discardD = discardQ - 1'b1;
      end
      case (stateQ)
        FETCH: begin
          if (memRd) begin
            addrD    = addrQ + 1'b1;
            fetchedD = fetchedQ + 1'b1;
            if (fetchedQ == CNT_W'(WORDS - 1)) begin
              stateD = DRAIN;
            end
          end
        end
        DRAIN: begin
          if ((outstQ == '0) && (countQ == '0)) begin
            stateD = IDLE;
          end
        end
        default: ;
      endcase
      if (pop) begin
        pixDataD  = headPix;
        pixValidD = 1'b1;
      end else if (bus_io.pixel_req) begin
        pixDataD   = '0;
        underflowD = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ     <= IDLE;
      addrQ      <= BASE;
      fetchedQ   <= '0;
      outstQ     <= '0;
      discardQ   <= '0;
      countQ     <= '0;
      rdPtrQ     <= '0;
      wrPtrQ     <= '0;
      pixDataQ   <= '0;
      pixValidQ  <= 1'b0;
      underflowQ <= 1'b0;
`ifdef PIXEL_PACK_EN
      idxQ       <= 2'd0;
`endif
    end else begin
      stateQ     <= stateD;
      addrQ      <= addrD;
      fetchedQ   <= fetchedD;
      outstQ     <= outstD;
      discardQ   <= discardD;
      countQ     <= countD;
      rdPtrQ     <= rdPtrD;
      wrPtrQ     <= wrPtrD;
      pixDataQ   <= pixDataD;
      pixValidQ  <= pixValidD;
      underflowQ <= underflowD;
`ifdef PIXEL_PACK_EN
      idxQ       <= idxD;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem[wrPtrQ] <= pushData;
    end
  end

  assign bus_io.mem_rd      = memRd;
  assign bus_io.mem_addr    = addrQ;
  assign bus_io.pixel_data  = pixDataQ;
  assign bus_io.pixel_valid = pixValidQ;
  assign bus_io.underflow   = underflowQ;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Bench for vga_pixel_fetch: latency-configurable memory model feeding a pixel scoreboard.
// Honours PIXEL_PACK_EN (frame widened so the word count per frame stays at 16).
module tb_vga_pixel_fetch;
`ifdef PIXEL_PACK_EN
  localparam int H = 32;
  localparam int PPW = 4;
  localparam logic [3:0] FIRST_PIX = 4'd1;
`else
  localparam int H = 8;
  localparam int PPW = 1;
  localparam logic [3:0] FIRST_PIX = 4'd0;
`endif
  localparam int V = 2;
  localparam int WORDS = H * V / PPW;
  localparam int NPIX = H * V;
  localparam logic [23:0] BASE = 24'h000100;

  typedef struct {
    int          due;
    logic [15:0] data;
  } rsp_t;

  logic clk;
  logic rst;
  vga_pixel_fetch_if #(.ADDR_W(24), .PIX_W(4)) bus ();

  vga_pixel_fetch #(
    .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(24), .BASE_ADDR(32'h100),
    .FIFO_DEPTH(8), .PIX_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int reqCount = 0;
  int delivered = 0;
  int memLatency = 3;
  logic [3:0] memXor = 4'h0;
  logic [3:0] firstPix = 4'h0;
  logic [23:0] firstAddr = '0;
  bit needFirstAddr = 0;
  rsp_t pend[$];
  logic [3:0] sb[$];

  // Memory contents: the address itself, or four ascending nibbles when packing.
  function automatic logic [15:0] memWord(logic [23:0] a, logic [3:0] x);
`ifdef PIXEL_PACK_EN
    logic [3:0] n;
    n = a[3:0] ^ x;
    return {n + 4'd4, n + 4'd3, n + 4'd2, n + 4'd1};
`else
    return a[15:0] ^ {12'h000, x};
`endif
  endfunction

  // One clock: capture requests, clock, score any delivered pixel, drive memory returns.
  task automatic step();
    rsp_t r;
    #1;
    if (bus.mem_rd === 1'b1) begin
      reqCount++;
      if (needFirstAddr) begin
        firstAddr     = bus.mem_addr;
        needFirstAddr = 0;
      end
      r.due  = cycle + 1 + memLatency;
      r.data = memWord(bus.mem_addr, memXor);
      pend.push_back(r);
      for (int j = 0; j < PPW; j++) sb.push_back(r.data[j*4 +: 4]);
    end
    if (bus.frame_start === 1'b1) begin
      sb.delete();
      needFirstAddr = 1;
    end
    @(posedge clk);
    cycle++;
    #1;
    if (bus.pixel_valid === 1'b1) begin
      total++;
      delivered++;
      if (sb.size() == 0) begin
        bad++;
        $display("[TB] FAIL pixel_extra: got %h with nothing expected", bus.pixel_data);
      end else begin
        logic [3:0] exp;
        exp = sb.pop_front();
        if (delivered == 1) firstPix = bus.pixel_data;
        if (bus.pixel_data !== exp) begin
          bad++;
          $display("[TB] FAIL pixel_value: got %h expected %h", bus.pixel_data, exp);
        end
      end
    end
    bus.mem_rvalid = 1'b0;
    if (pend.size() > 0 && pend[0].due <= cycle + 1) begin
      r = pend.pop_front();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = r.data;
    end
  endtask

  task automatic resetDut();
    bus.frame_start = 1'b0;
    bus.pixel_req   = 1'b0;
    bus.mem_rvalid  = 1'b0;
    bus.mem_rdata   = '0;
    rst = 1'b1;
    pend.delete();
    step();
    step();
    pend.delete();
    sb.delete();
    bus.mem_rvalid = 1'b0;
    rst = 1'b0;
    reqCount  = 0;
    delivered = 0;
  endtask

  task automatic test_reset();
    resetDut();
    #1;
    total++; if (bus.mem_rd !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_rd: got %b expected 0", bus.mem_rd); end
    total++; if (bus.mem_addr !== BASE) begin bad++; $display("[TB] FAIL reset_mem_addr: got %h expected %h", bus.mem_addr, BASE); end
    total++; if (bus.pixel_data !== 4'h0) begin bad++; $display("[TB] FAIL reset_pixel_data: got %h expected 0", bus.pixel_data); end
    total++; if (bus.pixel_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_pixel_valid: got %b expected 0", bus.pixel_valid); end
    total++; if (bus.underflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_underflow: got %b expected 0", bus.underflow); end
  endtask

  task automatic test_credit_limit();
    memLatency = 3;
    memXor = 4'h0;
    bus.frame_start = 1'b1; step(); bus.frame_start = 1'b0;
    for (int i = 0; i < 20; i++) step();
    total++; if (reqCount !== 8) begin bad++; $display("[TB] FAIL credit_reqs: got %0d expected 8", reqCount); end
    total++; if (bus.mem_rd !== 1'b0) begin bad++; $display("[TB] FAIL credit_stall: got %b expected 0", bus.mem_rd); end
    total++; if (firstAddr !== BASE) begin bad++; $display("[TB] FAIL first_addr: got %h expected %h", firstAddr, BASE); end
    bus.pixel_req = 1'b1;
    for (int i = 0; i < PPW; i++) step();
    bus.pixel_req = 1'b0;
    for (int i = 0; i < 10; i++) step();
    total++; if (reqCount !== 9) begin bad++; $display("[TB] FAIL credit_refill: got %0d expected 9", reqCount); end
    total++; if (delivered !== PPW) begin bad++; $display("[TB] FAIL credit_popped: got %0d expected %0d", delivered, PPW); end
    total++; if (firstPix !== FIRST_PIX) begin bad++; $display("[TB] FAIL first_pixel: got %h expected %h", firstPix, FIRST_PIX); end
  endtask

  task automatic test_full_frame();
    bus.pixel_req = 1'b1;
    for (int i = 0; i < NPIX - PPW; i++) begin
      step();
      total++;
      if (bus.pixel_valid !== 1'b1) begin bad++; $display("[TB] FAIL stream_valid: got %b expected 1", bus.pixel_valid); end
    end
    bus.pixel_req = 1'b0;
    for (int i = 0; i < 20; i++) step();
    total++; if (reqCount !== WORDS) begin bad++; $display("[TB] FAIL frame_reqs: got %0d expected %0d", reqCount, WORDS); end
    total++; if (delivered !== NPIX) begin bad++; $display("[TB] FAIL frame_pixels: got %0d expected %0d", delivered, NPIX); end
    total++; if (bus.underflow !== 1'b0) begin bad++; $display("[TB] FAIL frame_underflow: got %b expected 0", bus.underflow); end
    total++; if (bus.mem_rd !== 1'b0) begin bad++; $display("[TB] FAIL frame_idle_rd: got %b expected 0", bus.mem_rd); end
  endtask

  task automatic test_underflow();
    memLatency = 5;
    delivered = 0;
    bus.frame_start = 1'b1; step(); bus.frame_start = 1'b0;
    step();
    bus.pixel_req = 1'b1; step(); bus.pixel_req = 1'b0;
    total++; if (bus.pixel_valid !== 1'b0) begin bad++; $display("[TB] FAIL under_valid: got %b expected 0", bus.pixel_valid); end
    total++; if (bus.pixel_data !== 4'h0) begin bad++; $display("[TB] FAIL under_data: got %h expected 0", bus.pixel_data); end
    total++; if (bus.underflow !== 1'b1) begin bad++; $display("[TB] FAIL under_flag: got %b expected 1", bus.underflow); end
    bus.pixel_req = 1'b1;
    for (int i = 0; i < 400 && delivered < NPIX; i++) step();
    bus.pixel_req = 1'b0;
    total++; if (delivered !== NPIX) begin bad++; $display("[TB] FAIL under_drain: got %0d expected %0d", delivered, NPIX); end
    total++; if (bus.underflow !== 1'b1) begin bad++; $display("[TB] FAIL under_sticky: got %b expected 1", bus.underflow); end
  endtask

  task automatic test_restart();
    resetDut();
    total++; if (bus.underflow !== 1'b0) begin bad++; $display("[TB] FAIL restart_rst_underflow: got %b expected 0", bus.underflow); end
    memLatency = 10;
    memXor = 4'h5;
    bus.frame_start = 1'b1; step(); bus.frame_start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    total++; if (reqCount !== 3) begin bad++; $display("[TB] FAIL restart_inflight: got %0d expected 3", reqCount); end
    bus.frame_start = 1'b1;
    #1;
    total++; if (bus.mem_rd !== 1'b0) begin bad++; $display("[TB] FAIL restart_rd_in_fs: got %b expected 0", bus.mem_rd); end
    step();
    bus.frame_start = 1'b0;
    memXor = 4'h0;
    reqCount = 0;
    delivered = 0;
    for (int i = 0; i < 30; i++) step();
    total++; if (firstAddr !== BASE) begin bad++; $display("[TB] FAIL restart_addr: got %h expected %h", firstAddr, BASE); end
    bus.pixel_req = 1'b1;
    for (int i = 0; i < 400 && delivered < NPIX; i++) step();
    bus.pixel_req = 1'b0;
    for (int i = 0; i < 5; i++) step();
    total++; if (firstPix !== FIRST_PIX) begin bad++; $display("[TB] FAIL restart_first_pixel: got %h expected %h", firstPix, FIRST_PIX); end
    total++; if (delivered !== NPIX) begin bad++; $display("[TB] FAIL restart_pixels: got %0d expected %0d", delivered, NPIX); end
    total++; if (reqCount !== WORDS) begin bad++; $display("[TB] FAIL restart_reqs: got %0d expected %0d", reqCount, WORDS); end
  endtask

  task automatic test_flush_vs_pop();
    resetDut();
    memLatency = 3;
    memXor = 4'h0;
    bus.frame_start = 1'b1; step(); bus.frame_start = 1'b0;
    for (int i = 0; i < 15; i++) step();
    bus.frame_start = 1'b1;
    bus.pixel_req = 1'b1;
    step();
    bus.frame_start = 1'b0;
    bus.pixel_req = 1'b0;
    total++; if (bus.pixel_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_valid: got %b expected 0", bus.pixel_valid); end
    total++; if (bus.underflow !== 1'b0) begin bad++; $display("[TB] FAIL flush_underflow: got %b expected 0", bus.underflow); end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_credit_limit();
    test_full_frame();
    test_underflow();
    test_restart();
    test_flush_vs_pop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
